// File: rtl/ysyx_23060236_rd_arbiter.sv
// rtl/ysyx_23060236_rd_arbiter.sv - IFU/LSU read-channel arbiter onto one AR/R master port
// Optional: define ARB_TIMEOUT_EN for a synthetic SLVERR after TIMEOUT silent DATA cycles.
module ysyx_23060236_rd_arbiter #(
    parameter int PRIO_MODE = 1,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [31:0] ifu_araddr,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,

    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    input  logic [31:0] lsu_araddr,
    input  logic [2:0]  lsu_arsize,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,

    output logic        io_master_arvalid,
    input  logic        io_master_arready,
    output logic [31:0] io_master_araddr,
    output logic [2:0]  io_master_arsize,
    input  logic        io_master_rvalid,
    output logic        io_master_rready,
    input  logic [31:0] io_master_rdata,
    input  logic [1:0]  io_master_rresp
);

`ifdef ARB_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;
`endif

    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    if (TIMEOUT < 1 || TIMEOUT > 65536) begin : g_timeout_range
        $error("TIMEOUT must fit the 16-bit timeout counter");
    end

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;

    logic        gnt_arvalid;
    logic        gnt_rready;
    logic        tie_winner;
    logic        r_valid;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
    logic [15:0] cnt_q, cnt_d;
`endif

    assign gnt_arvalid = (grant_q == GNT_LSU) ? lsu_arvalid : ifu_arvalid;
    assign gnt_rready  = (grant_q == GNT_LSU) ? lsu_rready  : ifu_rready;
    // Round-robin hands a tie to whoever did not win the last completed AR.
    assign tie_winner  = (PRIO_MODE == 0) ? GNT_LSU : ~last_grant_q;

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        last_grant_d      = last_grant_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d             = cnt_q;
`endif
        io_master_arvalid = 1'b0;
        io_master_araddr  = 32'h0;
        io_master_arsize  = 3'b000;
        io_master_rready  = 1'b0;
        ifu_arready       = 1'b0;
        lsu_arready       = 1'b0;
        r_valid           = 1'b0;
        r_data            = 32'h0;
        r_resp            = 2'b00;

        unique case (state_q)
            S_IDLE: begin
                if (ifu_arvalid || lsu_arvalid) begin
                    state_d = S_ADDR;
                    grant_d = (ifu_arvalid && lsu_arvalid) ? tie_winner : lsu_arvalid;
                end
            end
            S_ADDR: begin
                io_master_arvalid = gnt_arvalid;
                if (grant_q == GNT_LSU) begin
                    io_master_araddr = lsu_araddr;
                    io_master_arsize = lsu_arsize;
                    lsu_arready      = io_master_arready;
                end else begin
                    io_master_araddr = ifu_araddr;
                    io_master_arsize = 3'b010;
                    ifu_arready      = io_master_arready;
                end
                if (gnt_arvalid && io_master_arready) begin
                    state_d      = S_DATA;
                    last_grant_d = grant_q;
`ifdef ARB_TIMEOUT_EN
                    cnt_d        = 16'h0;
`endif
                end else if (!gnt_arvalid) begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
`ifdef ARB_TIMEOUT_EN
                if (io_master_rvalid || cnt_q != TIMEOUT_M1) begin
                    r_valid          = io_master_rvalid;
                    r_data           = io_master_rdata;
                    r_resp           = io_master_rresp;
                    io_master_rready = gnt_rready;
                    if (io_master_rvalid && gnt_rready) begin
                        state_d = S_IDLE;
                    end else if (!io_master_rvalid) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    // Slave went silent: answer SLVERR ourselves, swallow its beat later.
                    r_valid = 1'b1;
                    r_resp  = 2'b10;
                    if (gnt_rready) begin
                        state_d = S_DRAIN;
                    end
                end
`else
                r_valid          = io_master_rvalid;
                r_data           = io_master_rdata;
                r_resp           = io_master_rresp;
                io_master_rready = gnt_rready;
                if (io_master_rvalid && gnt_rready) begin
                    state_d = S_IDLE;
                end
`endif
            end
`ifdef ARB_TIMEOUT_EN
            S_DRAIN: begin
                io_master_rready = 1'b1;
                if (io_master_rvalid) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ifu_rvalid = 1'b0;
        ifu_rdata  = 32'h0;
        ifu_rresp  = 2'b00;
        lsu_rvalid = 1'b0;
        lsu_rdata  = 32'h0;
        lsu_rresp  = 2'b00;
        if (grant_q == GNT_LSU) begin
            lsu_rvalid = r_valid;
            lsu_rdata  = r_data;
            lsu_rresp  = r_resp;
        end else begin
            ifu_rvalid = r_valid;
            ifu_rdata  = r_data;
            ifu_rresp  = r_resp;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            grant_q      <= GNT_IFU;
            last_grant_q <= GNT_IFU;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= 16'h0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060236_rd_arbiter.sv
// tb/tb_ysyx_23060236_rd_arbiter.sv - directed vector bench for the read-channel arbiter
module tb_ysyx_23060236_rd_arbiter;

    localparam logic [31:0] IA   = 32'h8000_0000;
    localparam logic [31:0] LA   = 32'ha000_0048;
    localparam logic [2:0]  LS   = 3'b001;
    localparam logic [2:0]  ISZ  = 3'b010;
    localparam logic [31:0] DB   = 32'hdead_beef;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready;
    logic [31:0] ifu_araddr, lsu_araddr;
    logic [2:0]  lsu_arsize;
    logic        io_master_arready, io_master_rvalid;
    logic [31:0] io_master_rdata;
    logic [1:0]  io_master_rresp;

    // round-robin instance outputs
    logic        ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid;
    logic [31:0] ifu_rdata, lsu_rdata, io_master_araddr;
    logic [1:0]  ifu_rresp, lsu_rresp;
    logic        io_master_arvalid, io_master_rready;
    logic [2:0]  io_master_arsize;

    // fixed-priority instance outputs
    logic        f_ifu_arready, f_ifu_rvalid, f_lsu_arready, f_lsu_rvalid;
    logic [31:0] f_ifu_rdata, f_lsu_rdata, f_araddr;
    logic [1:0]  f_ifu_rresp, f_lsu_rresp;
    logic        f_arvalid, f_rready;
    logic [2:0]  f_arsize;

    always #5 clock = ~clock;

    ysyx_23060236_rd_arbiter #(.PRIO_MODE(1), .TIMEOUT(8)) dut_rr (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
        .io_master_araddr(io_master_araddr), .io_master_arsize(io_master_arsize),
        .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
        .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp)
    );

    ysyx_23060236_rd_arbiter #(.PRIO_MODE(0), .TIMEOUT(8)) dut_fix (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(f_ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_rvalid(f_ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(f_ifu_rdata), .ifu_rresp(f_ifu_rresp),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(f_lsu_arready), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize),
        .lsu_rvalid(f_lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(f_lsu_rdata), .lsu_rresp(f_lsu_rresp),
        .io_master_arvalid(f_arvalid), .io_master_arready(io_master_arready),
        .io_master_araddr(f_araddr), .io_master_arsize(f_arsize),
        .io_master_rvalid(io_master_rvalid), .io_master_rready(f_rready),
        .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp)
    );

    logic [108:0] obs_rr, obs_fix;
    assign obs_rr  = {io_master_arvalid, io_master_rready, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid,
                      io_master_araddr, io_master_arsize, ifu_rdata, lsu_rdata, ifu_rresp, lsu_rresp};
    assign obs_fix = {f_arvalid, f_rready, f_ifu_arready, f_lsu_arready, f_ifu_rvalid, f_lsu_rvalid,
                      f_araddr, f_arsize, f_ifu_rdata, f_lsu_rdata, f_ifu_rresp, f_lsu_rresp};

    typedef struct {
        logic [5:0]   in_ctl;  // {ifu_arvalid, lsu_arvalid, m_arready, m_rvalid, ifu_rready, lsu_rready}
        logic [31:0]  rdata;
        logic [1:0]   rresp;
        logic [108:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [111:0] act, input logic [111:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic [5:0] ic, input logic [31:0] rd, input logic [1:0] rr,
                       input logic [5:0] ec, input logic [31:0] ea, input logic [2:0] es,
                       input logic [31:0] eir, input logic [31:0] elr,
                       input logic [1:0] eirr, input logic [1:0] elrr);
        vec_t v;
        v.in_ctl = ic;
        v.rdata  = rd;
        v.rresp  = rr;
        v.exp    = {ec, ea, es, eir, elr, eirr, elrr};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [5:0] ic, input logic [31:0] rd, input logic [1:0] rr);
        {ifu_arvalid, lsu_arvalid, io_master_arready, io_master_rvalid, ifu_rready, lsu_rready} = ic;
        io_master_rdata = rd;
        io_master_rresp = rr;
    endtask

    initial begin
        ifu_araddr = IA;
        lsu_araddr = LA;
        lsu_arsize = LS;
        drive(6'b110000, 32'h0, 2'b00);
        reset = 1'b0;

        // IFU-only read
        add(6'b100000, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 0);
        add(6'b100000, 0, 0, 6'b100000, IA, ISZ, 0, 0, 0, 0);
        add(6'b100000, 0, 0, 6'b100000, IA, ISZ, 0, 0, 0, 0);
        add(6'b101000, 0, 0, 6'b101000, IA, ISZ, 0, 0, 0, 0);
        add(6'b000010, 0, 0, 6'b010000, 0, 0, 0, 0, 0, 0);
        add(6'b000110, 32'h413, 0, 6'b010010, 0, 0, 32'h413, 0, 0, 0);
        add(6'b000000, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 0);
        // LSU read with 4 cycles of rready backpressure
        add(6'b010000, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 0);
        add(6'b011000, 0, 0, 6'b100100, LA, LS, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(6'b000110, DB, 2'b01, 6'b000001, 0, 0, 0, DB, 0, 2'b01);
        add(6'b000101, DB, 2'b01, 6'b010001, 0, 0, 0, DB, 0, 2'b01);
        add(6'b000000, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 0);
        // granted arvalid withdrawn in ADDR, then an LSU read
        add(6'b100000, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 0);
        add(6'b100000, 0, 0, 6'b100000, IA, ISZ, 0, 0, 0, 0);
        add(6'b000000, 0, 0, 6'b000000, IA, ISZ, 0, 0, 0, 0);
        add(6'b010000, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 0);
        add(6'b011000, 0, 0, 6'b100100, LA, LS, 0, 0, 0, 0);
        add(6'b000101, 32'h1234_5678, 0, 6'b010001, 0, 0, 0, 32'h1234_5678, 0, 0);
        add(6'b000000, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 0);

        @(negedge clock);
        #1 check("reset_outputs", 112'(obs_rr), 112'h0);
        @(negedge clock);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].in_ctl, vecs[i].rdata, vecs[i].rresp);
            #1 check($sformatf("vec%0d", i), 112'(obs_rr), 112'(vecs[i].exp));
            @(negedge clock);
        end

        // async reset while DATA holds an unaccepted beat
        drive(6'b010000, 0, 0);
        @(negedge clock);
        drive(6'b011000, 0, 0);
        @(negedge clock);
        drive(6'b000100, 32'hcafe_f00d, 2'b00);
        #1 check("pre_reset_rvalid", {79'h0, lsu_rvalid, lsu_rdata}, {79'h0, 1'b1, 32'hcafe_f00d});
        #1 reset = 1'b0;
        #1 check("async_reset_rr", 112'(obs_rr), 112'h0);
        check("async_reset_fix", 112'(obs_fix), 112'h0);
        @(negedge clock);
        drive(6'b111111, 32'h0, 2'b00);
        reset = 1'b1;
        #1 check("post_reset_idle", 112'(obs_rr), 112'h0);

        // continuous tie: round-robin alternates, fixed priority keeps LSU
        for (int n = 0; n < 4; n++) begin
            @(negedge clock);
            #1 check($sformatf("tie_rr%0d", n), {79'h0, io_master_arvalid, io_master_araddr},
                     {79'h0, 1'b1, (n % 2 == 0) ? LA : IA});
            check($sformatf("tie_fix%0d", n), {79'h0, f_arvalid, f_araddr}, {79'h0, 1'b1, LA});
            @(negedge clock);
            @(negedge clock);
        end
        lsu_arvalid = 1'b0;
        @(negedge clock);
        #1 check("fix_ifu_after_lsu_drop", {76'h0, f_arvalid, f_araddr, f_arsize}, {76'h0, 1'b1, IA, ISZ});
        @(negedge clock);
        ifu_arvalid = 1'b0;
        @(negedge clock);
        drive(6'b000000, 0, 0);
        #1 check("idle_after_ties", 112'(obs_rr), 112'h0);

`ifdef ARB_TIMEOUT_EN
        begin
            int early = 0;
            drive(6'b100000, 0, 0);
            @(negedge clock);
            drive(6'b101000, 0, 0);
            @(negedge clock);
            drive(6'b000010, 32'h55, 2'b00);
            for (int i = 1; i < 8; i++) begin
                #1 if (ifu_rvalid) early++;
                @(negedge clock);
            end
            check("timeout_no_early_rvalid", 112'(early), 112'h0);
            #1 check("timeout_slverr", {77'h0, ifu_rvalid, ifu_rresp, ifu_rdata, io_master_rready},
                     {77'h0, 1'b1, 2'b10, 32'h0, 1'b0});
            @(negedge clock);
            drive(6'b000110, 32'h0bad, 2'b00);
            #1 check("drain_absorb", {109'h0, io_master_rready, ifu_rvalid, lsu_rvalid}, {109'h0, 3'b100});
            @(negedge clock);
            drive(6'b000000, 0, 0);
            #1 check("idle_after_drain", 112'(obs_rr), 112'h0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
